// File: rtl/spi_shift_engine_pkg.sv
// Shared types and bit-order helpers for the SPI shift engine.
package spi_pkg;

  localparam int unsigned SPI_MAX_W     = 64;
  localparam int unsigned SPI_MAX_IDX_W = $clog2(SPI_MAX_W);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  typedef struct packed {
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  // Word position of the idx-th bit on the wire for the given bit order.
  function automatic int unsigned bit_pos(input int unsigned idx, input int unsigned width,
                                          input logic lsb_first);
    return lsb_first ? idx : (width - 1 - idx);
  endfunction

  function automatic logic bit_sel(input logic [SPI_MAX_W-1:0] word, input int unsigned idx,
                                   input int unsigned width, input logic lsb_first);
    return word[SPI_MAX_IDX_W'(bit_pos(idx, width, lsb_first))];
  endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// TX holding-buffer handshake and RX word delivery between controller and shift engine.
interface spi_shift_engine_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: DATA_W frames, CPHA 0/1, MSB/LSB-first, one-entry TX buffer.
// SCLK edges arrive as single-cycle lead/trail strobes on the system clock.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter logic        IDLE_MOSI = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  spi_shift_engine_if.slave   bus,
  input  logic                lsb_first,
  input  logic                cpha,
  input  logic                lead_stb,
  input  logic                trail_stb,
  input  logic                miso,
  output logic                mosi,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [0:0]  ST_IDLE  = IDLE;
  localparam logic [0:0]  ST_SHIFT = SHIFT;

  logic [0:0]        r_state,     w_state_nxt;
  logic [DATA_W-1:0] r_buf,       w_buf_nxt;
  logic              r_buf_full,  w_buf_full_nxt;
  logic [DATA_W-1:0] r_tx_shift,  w_tx_shift_nxt;
  logic [DATA_W-1:0] r_rx_shift,  w_rx_shift_nxt;
  logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
  spi_mode_t         r_mode,      w_mode_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              r_mosi,      w_mosi_nxt;
  logic [DATA_W-1:0] r_rx_data,   w_rx_data_nxt;
  logic              r_rx_valid,  w_rx_valid_nxt;

  logic w_lead, w_trail, w_sample, w_drive, w_end, w_load;

  // Colliding strobes are both dropped.
  assign w_lead   = lead_stb & ~trail_stb;
  assign w_trail  = trail_stb & ~lead_stb;
  assign w_sample = r_mode.cpha ? w_trail : w_lead;
  assign w_drive  = r_mode.cpha ? w_lead  : w_trail;

  always_comb begin
    w_state_nxt    = r_state;
    w_buf_nxt      = r_buf;
    w_buf_full_nxt = r_buf_full;
    w_tx_shift_nxt = r_tx_shift;
    w_rx_shift_nxt = r_rx_shift;
    w_cnt_nxt      = r_cnt;
    w_mode_nxt     = r_mode;
    w_busy_nxt     = r_busy;
    w_mosi_nxt     = r_mosi;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_end          = 1'b0;
    w_load         = 1'b0;

    if (bus.tx_valid && !r_buf_full) begin
      w_buf_nxt      = bus.tx_data;
      w_buf_full_nxt = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (r_buf_full) w_load = 1'b1;
      end
      ST_SHIFT: begin
        if (w_sample) begin
          w_rx_shift_nxt[IDX_W'(bit_pos(32'(r_cnt), DATA_W, r_mode.lsb_first))] = miso;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_mode.cpha && (w_cnt_nxt == CNT_W'(DATA_W))) w_end = 1'b1;
        end else if (w_drive) begin
          if (r_cnt == CNT_W'(DATA_W)) begin
            w_end = ~r_mode.cpha;
          end else begin
            w_mosi_nxt = bit_sel(SPI_MAX_W'(r_tx_shift), 32'(r_cnt), DATA_W, r_mode.lsb_first);
          end
        end
        if (w_end) begin
          w_rx_data_nxt  = w_rx_shift_nxt;
          w_rx_valid_nxt = 1'b1;
          if (r_buf_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_mosi_nxt  = IDLE_MOSI;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Frame load, shared by the IDLE start and the back-to-back reload.
    if (w_load) begin
      w_state_nxt    = ST_SHIFT;
      w_tx_shift_nxt = r_buf;
      w_buf_full_nxt = 1'b0;
      w_mode_nxt     = '{cpha: cpha, lsb_first: lsb_first};
      w_cnt_nxt      = '0;
      w_busy_nxt     = 1'b1;
      w_rx_shift_nxt = '0;
      if (!cpha) w_mosi_nxt = bit_sel(SPI_MAX_W'(r_buf), 32'd0, DATA_W, lsb_first);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_cnt      <= '0;
      r_mode     <= '0;
      r_busy     <= 1'b0;
      r_mosi     <= IDLE_MOSI;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_buf      <= w_buf_nxt;
      r_buf_full <= w_buf_full_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mode     <= w_mode_nxt;
      r_busy     <= w_busy_nxt;
      r_mosi     <= w_mosi_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end
  end

  assign bus.tx_ready = ~r_buf_full;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign mosi         = r_mosi;
  assign busy         = r_busy;

  a_strobe_collision: assert property (@(posedge clk) disable iff (rst) !(lead_stb && trail_stb))
    else $warning("spi_shift_engine: lead_stb and trail_stb in the same cycle, both ignored");

endmodule

// File: tb/tb_spi_shift_engine.sv
// Randomised bench for spi_shift_engine: 8-bit (IDLE_MOSI=0) and 16-bit (IDLE_MOSI=1) instances
// checked against a frame-level model of the wire bit order and RX assembly.
module tb_spi_shift_engine;

  localparam logic IDLE8  = 1'b0;
  localparam logic IDLE16 = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpha = 1'b0, lsb_first = 1'b0, lead_stb = 1'b0, trail_stb = 1'b0, miso = 1'b0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_word = '0;
  logic        sel = 1'b0;
  logic        mosi8, mosi16, busy8, busy16;
  logic        exp_hold = 1'b0;
  int          n_cmp = 0, n_bad = 0;
  int          n_rxv8 = 0, n_rxv16 = 0, exp_rxv8 = 0, exp_rxv16 = 0;

  spi_shift_engine_if #(.DATA_W(8))  if8();
  spi_shift_engine_if #(.DATA_W(16)) if16();

  assign if8.tx_data   = tx_word[7:0];
  assign if8.tx_valid  = tx_valid & ~sel;
  assign if16.tx_data  = tx_word;
  assign if16.tx_valid = tx_valid & sel;

  spi_shift_engine #(.DATA_W(8), .IDLE_MOSI(IDLE8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(if8), .lsb_first(lsb_first), .cpha(cpha),
    .lead_stb(lead_stb), .trail_stb(trail_stb), .miso(miso), .mosi(mosi8), .busy(busy8));

  spi_shift_engine #(.DATA_W(16), .IDLE_MOSI(IDLE16)) u_dut16 (
    .clk(clk), .rst(rst), .bus(if16), .lsb_first(lsb_first), .cpha(cpha),
    .lead_stb(lead_stb), .trail_stb(trail_stb), .miso(miso), .mosi(mosi16), .busy(busy16));

  always #5 clk = ~clk;

  logic        cur_mosi, cur_busy, cur_ready, cur_rxv, cur_idle;
  logic [15:0] cur_rx;
  always_comb begin
    if (sel) begin
      cur_mosi = mosi16; cur_busy = busy16; cur_ready = if16.tx_ready;
      cur_rxv = if16.rx_valid; cur_rx = if16.rx_data; cur_idle = IDLE16;
    end else begin
      cur_mosi = mosi8; cur_busy = busy8; cur_ready = if8.tx_ready;
      cur_rxv = if8.rx_valid; cur_rx = {8'h00, if8.rx_data}; cur_idle = IDLE8;
    end
  end

  always @(negedge clk) begin
    if (if8.rx_valid)  n_rxv8++;
    if (if16.rx_valid) n_rxv16++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic strobe(input logic l, input logic t);
    lead_stb = l; trail_stb = t;
    tick();
    lead_stb = 1'b0; trail_stb = 1'b0;
  endtask

  task automatic push(input logic [15:0] w);
    logic ok;
    ok = 1'b0;
    tx_word = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cur_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    tx_valid = 1'b0;
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  // Push from IDLE; busy must rise exactly two cycles after the handshake cycle.
  task automatic start(input logic s, input logic [15:0] w, input logic cp, input logic lsb);
    sel = s; cpha = cp; lsb_first = lsb;
    push(w);
    chk("lat_busy_n1", 32'(cur_busy), 32'd0);
    tick();
    chk("lat_busy_n2", 32'(cur_busy), 32'd1);
    exp_hold = cur_idle;
  endtask

  // mmode: 0 random miso, 1 loopback, 2 fixed word mw.
  task automatic run_frame(input int w, input logic [15:0] word, input logic cp, input logic lsb,
                           input int mmode, input logic [15:0] mw, input logic more,
                           input logic collide);
    logic [15:0] got, mexp, rexp;
    logic m;
    got = '0; mexp = '0; rexp = '0;
    for (int k = 0; k < w; k++) mexp[4'(k)] = lsb ? word[4'(k)] : word[4'(w - 1 - k)];
    if (cp) chk("cpha1_hold", 32'(cur_mosi), 32'(exp_hold));
    for (int k = 0; k < w; k++) begin
      if (k == 1) begin cpha = 1'($urandom); lsb_first = 1'($urandom); end
      if (k == w - 1) begin cpha = cp; lsb_first = lsb; end
      if (cp) begin gap(); strobe(1'b1, 1'b0); end
      if (mmode == 1)      m = cur_mosi;
      else if (mmode == 2) m = lsb ? mw[4'(k)] : mw[4'(w - 1 - k)];
      else                 m = 1'($urandom);
      miso = m;
      got[4'(k)] = cur_mosi;
      rexp[4'(lsb ? k : w - 1 - k)] = m;
      gap();
      strobe(~cp, cp);
      if (collide && k == 2) begin gap(); strobe(1'b1, 1'b1); end
      if (!cp) begin gap(); strobe(1'b0, 1'b1); end
    end
    if (sel) exp_rxv16++; else exp_rxv8++;
    chk("rx_valid_pulse", 32'(cur_rxv), 32'd1);
    chk("rx_data", 32'(cur_rx), 32'(rexp));
    chk("mosi_seq", 32'(got), 32'(mexp));
    chk("busy_after_end", 32'(cur_busy), 32'(more));
    chk("tx_ready_after_end", 32'(cur_ready), 32'd1);
    if (!more) chk("mosi_idle", 32'(cur_mosi), 32'(cur_idle));
    exp_hold = more ? mexp[4'(w - 1)] : cur_idle;
    tick();
    chk("rx_valid_single", 32'(cur_rxv), 32'd0);
  endtask

  task automatic random_run(input logic s, input int w, input int n);
    logic [15:0] mask, word, nxt;
    logic cp, lsb, pend, more;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    pend = 1'b0; cp = 1'b0; lsb = 1'b0; nxt = '0; word = '0;
    for (int i = 0; i < n; i++) begin
      if (!pend) begin
        cp = 1'($urandom); lsb = 1'($urandom);
        word = 16'($urandom) & mask;
        start(s, word, cp, lsb);
      end else begin
        word = nxt;
      end
      more = (i < n - 1) && ($urandom_range(0, 2) == 0);
      if (more) begin
        nxt = 16'($urandom) & mask;
        push(nxt);
        chk("ready_while_full", 32'(cur_ready), 32'd0);
      end
      run_frame(w, word, cp, lsb, int'($urandom_range(0, 1)), 16'h0, more, i == 4);
      pend = more;
    end
  endtask

  initial begin
    int snap8, snap16;
    tick(); tick();
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_mosi8", 32'(mosi8), 32'(IDLE8));
    chk("rst_mosi16", 32'(mosi16), 32'(IDLE16));
    chk("rst_ready8", 32'(if8.tx_ready), 32'd1);
    chk("rst_rxdata16", 32'(if16.rx_data), 32'd0);
    chk("rst_rxvalid8", 32'(if8.rx_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Strobes with nothing queued must leave both engines idle.
    snap8 = n_rxv8; snap16 = n_rxv16;
    for (int i = 0; i < 20; i++) begin
      lead_stb = 1'($urandom);
      trail_stb = lead_stb ? 1'b0 : 1'($urandom);
      tick();
    end
    lead_stb = 1'b0; trail_stb = 1'b0;
    chk("idle_busy8", 32'(busy8), 32'd0);
    chk("idle_busy16", 32'(busy16), 32'd0);
    chk("idle_mosi8", 32'(mosi8), 32'(IDLE8));
    chk("idle_mosi16", 32'(mosi16), 32'(IDLE16));
    chk("idle_ready16", 32'(if16.tx_ready), 32'd1);
    chk("idle_no_rxv", n_rxv8 + n_rxv16, snap8 + snap16);

    start(1'b0, 16'h00A5, 1'b0, 1'b0);
    run_frame(8, 16'h00A5, 1'b0, 1'b0, 2, 16'h003C, 1'b0, 1'b0);
    chk("a5_rx_3c", 32'(if8.rx_data), 32'h3C);

    start(1'b0, 16'h0081, 1'b1, 1'b0);
    run_frame(8, 16'h0081, 1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b0);

    start(1'b1, 16'h1234, 1'b0, 1'b1);
    run_frame(16, 16'h1234, 1'b0, 1'b1, 1, 16'h0, 1'b0, 1'b0);
    chk("loop_rx_1234", 32'(if16.rx_data), 32'h1234);

    start(1'b0, 16'h0011, 1'b0, 1'b0);
    push(16'h0022);
    chk("b2b_ready_low", 32'(cur_ready), 32'd0);
    run_frame(8, 16'h0011, 1'b0, 1'b0, 2, 16'h00E1, 1'b1, 1'b0);
    run_frame(8, 16'h0022, 1'b0, 1'b0, 2, 16'h0047, 1'b0, 1'b0);

    start(1'b0, 16'h00C7, 1'b1, 1'b1);
    run_frame(8, 16'h00C7, 1'b1, 1'b1, 0, 16'h0, 1'b0, 1'b1);

    // Reset after three sample edges with a word waiting in the buffer.
    start(1'b0, 16'h0096, 1'b0, 1'b0);
    push(16'h00C3);
    for (int i = 0; i < 3; i++) begin
      gap(); strobe(1'b1, 1'b0);
      gap(); strobe(1'b0, 1'b1);
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_mosi", 32'(mosi8), 32'(IDLE8));
    chk("midrst_rxdata", 32'(if8.rx_data), 32'd0);
    chk("midrst_rxvalid", 32'(if8.rx_valid), 32'd0);
    chk("midrst_ready", 32'(if8.tx_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("midrst_buf_dropped", 32'(busy8), 32'd0);
    chk("midrst_no_rxv", n_rxv8, exp_rxv8);
    start(1'b0, 16'h005A, 1'b0, 1'b0);
    run_frame(8, 16'h005A, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0);

    random_run(1'b0, 8, 20);
    random_run(1'b1, 16, 8);

    repeat (3) tick();
    chk("rxv_count8", n_rxv8, exp_rxv8);
    chk("rxv_count16", n_rxv16, exp_rxv16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
